// File: rtl/mat_mult_seq.sv
// Sequential N x N unsigned matrix multiplier: C = A*B, or C = A*B + C_prev.
// One result element is issued per cycle through N parallel multipliers.
// The products are registered, and an N-input adder finishes the element in
// the next cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; clr honoured
// S_RUN   | issuing elements 0..N*N-1, one per cycle
// S_DRAIN | last registered products summed and written back
// S_DONE  | one-cycle done pulse; clr honoured, start restarts at once
module mat_mult_seq #(
  parameter  int N  = 4,
  parameter  int W  = 2,
  localparam int OW = 2*W + $clog2(N),
  localparam int IW = $clog2(N*N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 acc,
  input  logic                 clr,
  input  logic [N*N*W-1:0]     mat_A,
  input  logic [N*N*W-1:0]     mat_B,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [IW-1:0]        out_idx,
  output logic [OW-1:0]        out_data,
  output logic [N*N*OW-1:0]    mat_out
);

  localparam int NE = N*N;
  localparam int RW = $clog2(N);
  localparam int PW = 2*W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [NE*W-1:0] a_q, b_q;
  logic            acc_q;
  logic [IW-1:0]   issue_q;
  logic [RW-1:0]   row_q, col_q;

  logic [PW-1:0]   prod_d [N];
  logic [PW-1:0]   prod_q [N];
  logic            pv_q;
  logic [IW-1:0]   pidx_q;

  logic [OW-1:0]   sum;
  logic [OW-1:0]   res_old;
  logic [OW-1:0]   new_val;

  logic idle_or_done;
  logic accept;
  logic clr_ok;
  logic last_issue;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept       = start && idle_or_done;
  assign clr_ok       = clr && idle_or_done;
  assign last_issue   = (issue_q == IW'(NE-1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_issue) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  // Operand latch and issue counters (row/col kept separately to avoid a divider)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= 1'b0;
      issue_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (accept) begin
      a_q     <= mat_A;
      b_q     <= mat_B;
      acc_q   <= acc;
      issue_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (state_q == S_RUN) begin
      issue_q <= issue_q + 1'b1;
      if (col_q == RW'(N-1)) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // N parallel multipliers: A row row_q times B column col_q
  always_comb begin
    int          a_idx;
    int          b_idx;
    logic [W-1:0] a_el;
    logic [W-1:0] b_el;
    a_idx = 0;
    b_idx = 0;
    a_el  = '0;
    b_el  = '0;
    for (int k = 0; k < N; k++) begin
      a_idx     = int'(row_q) * N + k;
      b_idx     = k * N + int'(col_q);
      a_el      = a_q[(NE-1-a_idx)*W +: W];
      b_el      = b_q[(NE-1-b_idx)*W +: W];
      prod_d[k] = PW'(a_el) * PW'(b_el);
    end
  end

  // Product register stage, tagged with the element index it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) prod_q[k] <= '0;
      pv_q   <= 1'b0;
      pidx_q <= '0;
    end else begin
      pv_q <= (state_q == S_RUN);
      if (state_q == S_RUN) begin
        for (int k = 0; k < N; k++) prod_q[k] <= prod_d[k];
        pidx_q <= issue_q;
      end
    end
  end

  // Adder tree and optional accumulate onto the stored element (wraps mod 2^OW)
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + OW'(prod_q[k]);
    res_old = mat_out[(NE-1-int'(pidx_q))*OW +: OW];
    new_val = acc_q ? (res_old + sum) : sum;
  end

  // Result register: clear only when idle/done, otherwise write one element
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mat_out <= '0;
    end else if (clr_ok) begin
      mat_out <= '0;
    end else if (pv_q) begin
      mat_out[(NE-1-int'(pidx_q))*OW +: OW] <= new_val;
    end
  end

  // Element stream; held at zero between valid beats
  always_comb begin
    out_valid = pv_q;
    out_idx   = pv_q ? pidx_q  : '0;
    out_data  = pv_q ? new_val : '0;
  end

endmodule
